// File: rtl/unsigned_down_async_reset_timer.sv
// Loadable unsigned down-counter/timer with one-shot or auto-reload behaviour.
// A terminal event fires on the enabled edge that finds Q already at zero.
module unsigned_down_async_reset_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             CE,
    input  logic             L,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BUSY,
    output logic             DONE,
    output logic             EXP,
    output logic [1:0]       ST
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] r;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
            Q     <= '0;
            r     <= '0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (L) begin
                // Load wins over any terminal condition on the same edge.
                Q     <= D;
                r     <= D;
                state <= RUN;
            end else if (state == RUN && CE) begin
                if (Q != '0) begin
                    Q <= Q - ONE;
                end else begin
                    DONE <= 1'b1;
                    if (AUTO_RELOAD) begin
                        Q <= r;
                    end else begin
                        state <= EXPIRED;
                    end
                end
            end
        end
    end

    assign TC   = (Q == '0);
    assign BUSY = (state == RUN);
    assign EXP  = (state == EXPIRED);
    assign ST   = state;

endmodule
